// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-NUM_CH stream demultiplexer.
package demux_pkg;

    localparam int unsigned MAX_CH = 64;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Select width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry output register slice for a single demux channel.
// Holds one beat; can drain and reload in the same cycle for full throughput.
module demux_chan_slot
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free_c
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign o_valid  = (r_state == SLOT_FULL);
    assign o_data   = r_data;
    assign w_drain  = o_valid & i_ready;
    assign o_free_c = ~o_valid | i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_load)              w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_drain && !i_load)  w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Payload only moves on load, so it stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-NUM_CH stream demux with per-channel valid/ready slots.
// Optional statistics counters (beat_cnt, drop_cnt) under `DEMUX_STATS_EN.
module demux_stream_1xn
    import demux_pkg::*;
#(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  NUM_CH = 8,
`ifdef DEMUX_STATS_EN
    parameter int unsigned  CNT_W  = 16,
`endif
    localparam int unsigned SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     drop_pulse
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]         drop_cnt
`endif
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;

    if (NUM_CH < 2 || NUM_CH > MAX_CH || DATA_W < 1) begin : g_bad_cfg
        $error("demux_stream_1xn: unsupported NUM_CH or DATA_W");
    end

    logic [NUM_CH-1:0]   w_slot_free;
    logic [SEL_SPAN-1:0] w_free_pad;
    logic [NUM_CH-1:0]   w_load;
    logic                w_sel_ok;
    logic                w_accept;
    logic                w_drop;
    logic                r_drop_pulse;

    // Out-of-range selects are always accepted so a bad beat never wedges the producer.
    assign w_sel_ok   = (32'(in_sel) < NUM_CH);
    assign w_free_pad = SEL_SPAN'(w_slot_free);
    assign in_ready   = rst_n & enable & (~w_sel_ok | w_free_pad[in_sel]);
    assign w_accept   = in_valid & in_ready;
    assign w_drop     = w_accept & ~w_sel_ok;
    assign drop_pulse = r_drop_pulse;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        assign w_load[c] = w_accept & w_sel_ok & (in_sel == SEL_W'(c));

        demux_chan_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load[c]),
            .i_ready  (out_ready[c]),
            .i_data   (in_data),
            .o_valid  (out_valid[c]),
            .o_data   (out_data[c*DATA_W +: DATA_W]),
            .o_free_c (w_slot_free[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_drop_cnt;

    // Saturating per-channel handshake counters.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        logic [CNT_W-1:0] r_beat_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_beat_cnt <= '0;
            end else if (out_valid[c] && out_ready[c] && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end

        assign beat_cnt[c*CNT_W +: CNT_W] = r_beat_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: an 8-channel instance for directed/table tests and a
// 5-channel instance for out-of-range selects and randomized scoreboard checking.
module tb_demux_stream_1xn;

    localparam int unsigned DW = 8;
    localparam int unsigned N8 = 8;
    localparam int unsigned N5 = 5;
`ifdef DEMUX_STATS_EN
    localparam int unsigned CW8 = 16;
    localparam int unsigned CW5 = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             en8, v8, ir8, dp8;
    logic [DW-1:0]    d8;
    logic [2:0]       s8;
    logic [N8-1:0]    ov8, ordy8;
    logic [N8*DW-1:0] od8;

    logic             en5, v5, ir5, dp5;
    logic [DW-1:0]    d5;
    logic [2:0]       s5;
    logic [N5-1:0]    ov5, ordy5;
    logic [N5*DW-1:0] od5;

`ifdef DEMUX_STATS_EN
    logic [N8*CW8-1:0] bc8;
    logic [CW8-1:0]    dc8;
    logic [N5*CW5-1:0] bc5;
    logic [CW5-1:0]    dc5;
`endif

    demux_stream_1xn #(.DATA_W(DW), .NUM_CH(N8)
`ifdef DEMUX_STATS_EN
        , .CNT_W(CW8)
`endif
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .enable(en8), .in_valid(v8), .in_ready(ir8),
        .in_data(d8), .in_sel(s8), .out_valid(ov8), .out_ready(ordy8),
        .out_data(od8), .drop_pulse(dp8)
`ifdef DEMUX_STATS_EN
        , .beat_cnt(bc8), .drop_cnt(dc8)
`endif
    );

    demux_stream_1xn #(.DATA_W(DW), .NUM_CH(N5)
`ifdef DEMUX_STATS_EN
        , .CNT_W(CW5)
`endif
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .enable(en5), .in_valid(v5), .in_ready(ir5),
        .in_data(d5), .in_sel(s5), .out_valid(ov5), .out_ready(ordy5),
        .out_data(od5), .drop_pulse(dp5)
`ifdef DEMUX_STATS_EN
        , .beat_cnt(bc5), .drop_cnt(dc5)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic [N8-1:0] exp_valid;
    } vec_t;

    vec_t tbl[N8];

    // Scoreboard for the 5-channel instance: what each consumer is owed, plus event tallies.
    bit            m_held  [N5];
    logic [DW-1:0] m_val   [N5];
    int            m_beats [N5];
    bit            m_drop;
    int            m_drops;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        en8 = 1'($urandom); v8 = 1'($urandom); d8 = 8'($urandom); s8 = 3'($urandom); ordy8 = 8'($urandom);
        en5 = 1'($urandom); v5 = 1'($urandom); d5 = 8'($urandom); s5 = 3'($urandom); ordy5 = 5'($urandom);
        #2;
        for (int k = 0; k < 3; k++) begin
            en8 = 1'b1; en5 = 1'b1; v8 = 1'b1; v5 = 1'b1;
            s8 = 3'($urandom); s5 = 3'($urandom);
            #1;
            chk("rst_ready8", ir8, 0);
            chk("rst_ready5", ir5, 0);
            tick();
            chk("rst_valid8", ov8, 0);
            chk("rst_data8", od8, 0);
            chk("rst_drop8", dp8, 0);
            chk("rst_valid5", ov5, 0);
            chk("rst_data5", od5, 0);
            chk("rst_drop5", dp5, 0);
        end
        en8 = 1'b1; v8 = 1'b0; ordy8 = '1;
        en5 = 1'b1; v5 = 1'b0; ordy5 = '1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- out-of-range select on NUM_CH=5 ----------------
        v5 = 1'b1; s5 = 3'd6; d5 = 8'h77;
        #1;
        chk("oor_ready", ir5, 1);
        tick();
        chk("oor_drop_pulse", dp5, 1);
        chk("oor_no_valid", ov5, 0);
        v5 = 1'b0;
        tick();
        chk("oor_drop_clears", dp5, 0);
`ifdef DEMUX_STATS_EN
        chk("oor_drop_cnt", dc5, 1);
`endif

        // ---------------- randomized traffic vs scoreboard ----------------
        for (int c = 0; c < N5; c++) begin
            m_held[c] = 1'b0; m_val[c] = '0; m_beats[c] = 0;
        end
        m_drop = 1'b0;
        m_drops = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N5-1:0] expv;
            logic          rdy;
            expv = '0;
            for (int c = 0; c < N5; c++) begin
                expv[c] = m_held[c];
                if (m_held[c]) chk("rand_data", od5[c*DW +: DW], m_val[c]);
            end
            chk("rand_valid", ov5, expv);
            chk("rand_drop", dp5, m_drop);
`ifdef DEMUX_STATS_EN
            for (int c = 0; c < N5; c++)
                chk("rand_beat_cnt", bc5[c*CW5 +: CW5], 64'(sat(m_beats[c], 15)));
            chk("rand_drop_cnt", dc5, 64'(sat(m_drops, 15)));
`endif
            en5   = ($urandom_range(0, 9) != 0);
            v5    = ($urandom_range(0, 3) != 0);
            s5    = 3'($urandom_range(0, 7));
            d5    = 8'($urandom);
            ordy5 = 5'($urandom);
            #1;
            if (s5 >= 3'(N5)) rdy = en5;
            else              rdy = en5 && (!m_held[s5] || ordy5[s5]);
            chk("rand_ready", ir5, rdy);
            for (int c = 0; c < N5; c++) begin
                if (m_held[c] && ordy5[c]) begin
                    m_held[c] = 1'b0;
                    m_beats[c]++;
                end
            end
            m_drop = 1'b0;
            if (v5 && rdy) begin
                if (s5 < 3'(N5)) begin
                    m_held[s5] = 1'b1;
                    m_val[s5]  = d5;
                end else begin
                    m_drop = 1'b1;
                    m_drops++;
                end
            end
            tick();
        end
        v5 = 1'b0;

        // ---------------- table sweep on NUM_CH=8 ----------------
        for (int i = 0; i < N8; i++) begin
            tbl[i].sel       = 3'(i);
            tbl[i].data      = 8'hA0 + 8'(i);
            tbl[i].exp_ready = 1'b1;
            tbl[i].exp_valid = 8'(1 << i);
        end
        ordy8 = '1; en8 = 1'b1;
        for (int i = 0; i < N8; i++) begin
            s8 = tbl[i].sel; d8 = tbl[i].data; v8 = 1'b1;
            #1;
            chk("sweep_ready", ir8, tbl[i].exp_ready);
            tick();
            chk("sweep_valid", ov8, tbl[i].exp_valid);
            chk("sweep_data", od8[i*DW +: DW], tbl[i].data);
        end
        v8 = 1'b0;
        tick();
        chk("sweep_idle", ov8, 0);

        // ---------------- stall isolation ----------------
        ordy8 = 8'hF7;
        v8 = 1'b1; s8 = 3'd3; d8 = 8'h11;
        #1;
        chk("stall_first_ready", ir8, 1);
        tick();
        chk("stall_first_valid", ov8, 8'h08);
        s8 = 3'd3; d8 = 8'h22;
        #1;
        chk("stall_second_ready", ir8, 0);
        tick();
        chk("stall_hold_valid", ov8, 8'h08);
        chk("stall_hold_data", od8[3*DW +: DW], 8'h11);
        s8 = 3'd5; d8 = 8'h55;
        #1;
        chk("stall_other_ready", ir8, 1);
        tick();
        chk("stall_other_valid", ov8, 8'h28);
        chk("stall_other_data", od8[5*DW +: DW], 8'h55);
        chk("stall_still_data", od8[3*DW +: DW], 8'h11);
        v8 = 1'b0;
        tick();
        chk("stall_other_drained", ov8, 8'h08);
        ordy8 = '1;
        tick();
        chk("stall_released", ov8, 0);
        chk("stall_data_kept", od8[3*DW +: DW], 8'h11);

        // ---------------- back-to-back on one channel ----------------
        v8 = 1'b1; s8 = 3'd2;
        for (int k = 0; k < 4; k++) begin
            d8 = 8'h31 + 8'(k);
            #1;
            chk("b2b_ready", ir8, 1);
            tick();
            chk("b2b_valid", ov8, 8'h04);
            chk("b2b_data", od8[2*DW +: DW], 8'h31 + 8'(k));
        end
        v8 = 1'b0;
        tick();
        chk("b2b_idle", ov8, 0);
`ifdef DEMUX_STATS_EN
        chk("b2b_beat_cnt", bc8[2*CW8 +: CW8], 5);
        chk("dut8_drop_cnt", dc8, 0);
`endif

        // ---------------- enable low while slots drain ----------------
        ordy8 = '0;
        v8 = 1'b1; s8 = 3'd0; d8 = 8'h01;
        tick();
        s8 = 3'd1; d8 = 8'h02;
        tick();
        chk("en_filled", ov8, 8'h03);
        en8 = 1'b0; s8 = 3'd4; d8 = 8'h44;
        #1;
        chk("en_low_ready", ir8, 0);
        tick();
        chk("en_low_no_load", ov8, 8'h03);
        ordy8 = '1;
        tick();
        chk("en_low_drained", ov8, 0);
        chk("en_low_no_drop", dp8, 0);
        en8 = 1'b1; v8 = 1'b0;

        // ---------------- reset pulse while slots are full ----------------
        ordy8 = '0;
        v8 = 1'b1; s8 = 3'd6; d8 = 8'h66;
        tick();
        s8 = 3'd7; d8 = 8'h77;
        tick();
        v8 = 1'b0;
        chk("rstmid_filled", ov8, 8'hC0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", ov8, 0);
        chk("rstmid_data", od8, 0);
        chk("rstmid_ready", ir8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstmid_after", ov8, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
